// File: rtl/conv_add2nd_ctrl.sv
// Sequencing controller for the second-stage adder layer of a conv engine:
// it gates the adder enables, tracks in-flight results and walks the output map.
module conv_add2nd_ctrl #(
  parameter int MAP_W   = 7,
  parameter int MAP_H   = 7,
  parameter int ADD_LAT = 2,
  localparam int ROW_W  = (MAP_H > 1) ? $clog2(MAP_H) : 1,
  localparam int COL_W  = (MAP_W > 1) ? $clog2(MAP_W) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             add_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ROW_W-1:0] out_row,
  output logic [COL_W-1:0] out_col,
  output logic             busy,
  output logic             done
);

  localparam int NPOS  = MAP_W * MAP_H;
  localparam int CNT_W = $clog2(NPOS + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  state_e             state_q, state_d;
  logic [ADD_LAT-1:0] vld_q, vld_d, vld_shift;
  logic [CNT_W-1:0]   acc_q, acc_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic               running, advance, accept, consume, last_acc, last_out;

  always_comb begin
    running  = (state_q == RUN) || (state_q == DRAIN);
    advance  = running && (!vld_q[ADD_LAT-1] || out_ready);
    accept   = advance && (state_q == RUN) && in_valid;
    consume  = running && vld_q[ADD_LAT-1] && out_ready;
    last_acc = (acc_q == CNT_W'(NPOS - 1));
    last_out = (row_q == ROW_W'(MAP_H - 1)) && (col_q == COL_W'(MAP_W - 1));
  end

  // vld[0] receives the accept flag; a single-stage adder has nothing to shift.
  if (ADD_LAT == 1) begin : g_vld1
    assign vld_shift = accept;
  end else begin : g_vldn
    assign vld_shift = {vld_q[ADD_LAT-2:0], accept};
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    row_d   = row_q;
    col_d   = col_q;
    vld_d   = advance ? vld_shift : vld_q;

    if (consume) begin
      if (col_q == COL_W'(MAP_W - 1)) begin
        col_d = '0;
        row_d = (row_q == ROW_W'(MAP_H - 1)) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          acc_d   = '0;
          row_d   = '0;
          col_d   = '0;
        end
      end
      RUN: begin
        if (accept) begin
          acc_d = acc_q + 1'b1;
          if (last_acc) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (consume && last_out) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      vld_q   <= '0;
      acc_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      vld_q   <= vld_d;
      acc_q   <= acc_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end

  assign add_en    = advance;
  assign in_ready  = advance && (state_q == RUN);
  assign out_valid = vld_q[ADD_LAT-1];
  assign out_row   = row_q;
  assign out_col   = col_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);

endmodule
